// File: rtl/hssi_afu_xcvr_rst_seq.sv
// AFU-side HSSI transceiver reset sequencer: GBS init handshake, analog/digital reset release, lock monitoring.
// Optional serial loopback control enabled by defining HSSI_RST_SEQ_LPBK_EN.
module hssi_afu_xcvr_rst_seq #(
    parameter int NUM_LN     = 4,
    parameter int CNT_W      = 20,
    parameter int T_ANA_CYC  = 100,
    parameter int T_LTD_CYC  = 1000,
    parameter int T_INIT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              f2a_init_done,
    input  logic              f2a_tx_pll_locked,
    input  logic              f2a_tx_cal_busy,
    input  logic              f2a_rx_cal_busy,
    input  logic [NUM_LN-1:0] f2a_rx_is_lockedtodata,
    output logic              a2f_init_start,
    output logic [NUM_LN-1:0] a2f_tx_analogreset,
    output logic [NUM_LN-1:0] a2f_tx_digitalreset,
    output logic [NUM_LN-1:0] a2f_rx_analogreset,
    output logic [NUM_LN-1:0] a2f_rx_digitalreset,
    output logic [NUM_LN-1:0] a2f_rx_seriallpbken,
    input  logic              lpbk_en,
    output logic              tx_ready,
    output logic              rx_ready,
    output logic              err,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ANA  = 3'd2,
        S_TXW  = 3'd3,
        S_RXW  = 3'd4,
        S_RDY  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam int SW = 4 + NUM_LN;
    localparam logic [CNT_W-1:0] C_INIT_LAST = CNT_W'(T_INIT_CYC - 1);
    localparam logic [CNT_W-1:0] C_ANA_LAST  = CNT_W'(T_ANA_CYC - 1);
    localparam logic [CNT_W-1:0] C_LTD_LAST  = CNT_W'(T_LTD_CYC - 1);

    logic [SW-1:0]    r_sync1;
    logic [SW-1:0]    r_sync2;
    logic [SW-1:0]    w_async;
    logic             w_init_done;
    logic             w_pll;
    logic             w_txcal;
    logic             w_rxcal;
    logic             w_ltd_all;
    logic             w_lpbk_chg;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_init_start;
    logic             r_txar;
    logic             r_txdr;
    logic             r_rxar;
    logic             r_rxdr;
    logic             r_tx_ready;
    logic             r_rx_ready;
    logic             r_err;
    logic             r_start_q;

    assign w_async = {f2a_rx_is_lockedtodata, f2a_rx_cal_busy, f2a_tx_cal_busy,
                      f2a_tx_pll_locked, f2a_init_done};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
        end
    end

    assign w_init_done = r_sync2[0];
    assign w_pll       = r_sync2[1];
    assign w_txcal     = r_sync2[2];
    assign w_rxcal     = r_sync2[3];
    assign w_ltd_all   = &r_sync2[SW-1:4];

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef HSSI_RST_SEQ_LPBK_EN
    logic r_lpbk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lpbk_q <= 1'b0;
        end else if (r_state == S_IDLE || r_state == S_RDY) begin
            r_lpbk_q <= lpbk_en;
        end
    end

    assign w_lpbk_chg          = (r_state == S_RDY) && (lpbk_en != r_lpbk_q);
    assign a2f_rx_seriallpbken = {NUM_LN{r_lpbk_q}};
`else
    logic w_unused_lpbk;

    assign w_unused_lpbk       = lpbk_en;
    assign w_lpbk_chg          = 1'b0;
    assign a2f_rx_seriallpbken = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_init_start <= 1'b0;
            r_txar       <= 1'b1;
            r_txdr       <= 1'b1;
            r_rxar       <= 1'b1;
            r_rxdr       <= 1'b1;
            r_tx_ready   <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_err        <= 1'b0;
            r_start_q    <= 1'b0;
        end else begin
            r_start_q <= start;
            // Dropping start aborts any sequence; only ERR ignores it and waits for a fresh rising edge.
            if (!start && r_state != S_ERR) begin
                r_state      <= S_IDLE;
                r_cnt        <= '0;
                r_init_start <= 1'b0;
                r_txar       <= 1'b1;
                r_txdr       <= 1'b1;
                r_rxar       <= 1'b1;
                r_rxdr       <= 1'b1;
                r_tx_ready   <= 1'b0;
                r_rx_ready   <= 1'b0;
                r_err        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state      <= S_INIT;
                        r_cnt        <= '0;
                        r_init_start <= 1'b1;
                    end
                    S_INIT: begin
                        if (w_init_done) begin
                            r_init_start <= 1'b0;
                            r_state      <= S_ANA;
                            r_cnt        <= '0;
                        end else if (r_cnt == C_INIT_LAST) begin
                            r_init_start <= 1'b0;
                            r_state      <= S_ERR;
                            r_err        <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_ANA: begin
                        if (r_cnt == C_ANA_LAST) begin
                            r_state <= S_TXW;
                            r_txar  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_TXW: begin
                        if (w_pll && !w_txcal) begin
                            r_txdr     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_rxar     <= 1'b0;
                            r_state    <= S_RXW;
                            r_cnt      <= '0;
                        end
                    end
                    S_RXW: begin
                        if (w_rxcal || !w_ltd_all) begin
                            r_cnt <= '0;
                        end else if (r_cnt == C_LTD_LAST) begin
                            r_rxdr     <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_state    <= S_RDY;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_RDY: begin
                        // PLL loss outranks CDR loss: the whole link must re-sequence.
                        if (!w_pll) begin
                            r_state    <= S_ANA;
                            r_cnt      <= '0;
                            r_txar     <= 1'b1;
                            r_txdr     <= 1'b1;
                            r_rxar     <= 1'b1;
                            r_rxdr     <= 1'b1;
                            r_tx_ready <= 1'b0;
                            r_rx_ready <= 1'b0;
                        end else if (!w_ltd_all || w_lpbk_chg) begin
                            r_rxdr     <= 1'b1;
                            r_rx_ready <= 1'b0;
                            r_state    <= S_RXW;
                            r_cnt      <= '0;
                        end
                    end
                    S_ERR: begin
                        if (start && !r_start_q) begin
                            r_err        <= 1'b0;
                            r_state      <= S_INIT;
                            r_cnt        <= '0;
                            r_init_start <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign a2f_init_start      = r_init_start;
    assign a2f_tx_analogreset  = {NUM_LN{r_txar}};
    assign a2f_tx_digitalreset = {NUM_LN{r_txdr}};
    assign a2f_rx_analogreset  = {NUM_LN{r_rxar}};
    assign a2f_rx_digitalreset = {NUM_LN{r_rxdr}};
    assign tx_ready            = r_tx_ready;
    assign rx_ready            = r_rx_ready;
    assign err                 = r_err;
    assign state_o             = r_state;

endmodule

// File: tb/tb_hssi_afu_xcvr_rst_seq.sv
// Directed bench for hssi_afu_xcvr_rst_seq: table of stepped vectors plus hand-written corner sequences.
// Timing constants: T_ANA_CYC=10, T_LTD_CYC=20, T_INIT_CYC=50.
module tb_hssi_afu_xcvr_rst_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       f2a_init_done;
    logic       f2a_tx_pll_locked;
    logic       f2a_tx_cal_busy;
    logic       f2a_rx_cal_busy;
    logic [3:0] f2a_rx_is_lockedtodata;
    logic       a2f_init_start;
    logic [3:0] a2f_tx_analogreset;
    logic [3:0] a2f_tx_digitalreset;
    logic [3:0] a2f_rx_analogreset;
    logic [3:0] a2f_rx_digitalreset;
    logic [3:0] a2f_rx_seriallpbken;
    logic       lpbk_en;
    logic       tx_ready;
    logic       rx_ready;
    logic       err;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    hssi_afu_xcvr_rst_seq #(
        .NUM_LN    (4),
        .CNT_W     (20),
        .T_ANA_CYC (10),
        .T_LTD_CYC (20),
        .T_INIT_CYC(50)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .f2a_init_done         (f2a_init_done),
        .f2a_tx_pll_locked     (f2a_tx_pll_locked),
        .f2a_tx_cal_busy       (f2a_tx_cal_busy),
        .f2a_rx_cal_busy       (f2a_rx_cal_busy),
        .f2a_rx_is_lockedtodata(f2a_rx_is_lockedtodata),
        .a2f_init_start        (a2f_init_start),
        .a2f_tx_analogreset    (a2f_tx_analogreset),
        .a2f_tx_digitalreset   (a2f_tx_digitalreset),
        .a2f_rx_analogreset    (a2f_rx_analogreset),
        .a2f_rx_digitalreset   (a2f_rx_digitalreset),
        .a2f_rx_seriallpbken   (a2f_rx_seriallpbken),
        .lpbk_en               (lpbk_en),
        .tx_ready              (tx_ready),
        .rx_ready              (rx_ready),
        .err                   (err),
        .state_o               (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       done;
        logic       pll;
        logic       txcal;
        logic       rxcal;
        logic [3:0] ltd;
        int         n;
        logic [2:0] st;
        logic       ist;
        logic       er;
        logic       trdy;
        logic       rrdy;
        logic [15:0] rs;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic s, logic d, logic p, logic tc, logic rc, logic [3:0] l, int n,
                                logic [2:0] st, logic ist, logic er, logic tr, logic rr, logic [15:0] rs);
        vec_t v;
        v.start = s;  v.done = d;  v.pll = p;  v.txcal = tc;  v.rxcal = rc;  v.ltd = l;  v.n = n;
        v.st = st;  v.ist = ist;  v.er = er;  v.trdy = tr;  v.rrdy = rr;  v.rs = rs;
        tbl.push_back(v);
    endfunction

    // {state, init_start, err, tx_ready, rx_ready, txar, txdr, rxar, rxdr}
    function automatic logic [22:0] obs();
        return {state_o, a2f_init_start, err, tx_ready, rx_ready,
                a2f_tx_analogreset, a2f_tx_digitalreset, a2f_rx_analogreset, a2f_rx_digitalreset};
    endfunction

    function automatic logic [22:0] ex(logic [2:0] st, logic ist, logic er, logic tr, logic rr, logic [15:0] rs);
        return {st, ist, er, tr, rr, rs};
    endfunction

    task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k;
        k = 0;
        while (state_o !== s && k < budget) begin
            step(1);
            k++;
        end
        chk(name, 23'(state_o), 23'(s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //    st do pl tc rc ltd   n   st ist er tr rr rs
        add(0, 0, 1, 0, 0, 4'hF, 1,  0, 0, 0, 0, 0, 16'hFFFF);
        add(1, 0, 1, 0, 0, 4'hF, 1,  1, 1, 0, 0, 0, 16'hFFFF);
        add(1, 0, 1, 0, 0, 4'hF, 5,  1, 1, 0, 0, 0, 16'hFFFF);
        add(1, 1, 1, 0, 0, 4'hF, 2,  1, 1, 0, 0, 0, 16'hFFFF);
        add(1, 1, 1, 0, 0, 4'hF, 1,  2, 0, 0, 0, 0, 16'hFFFF);
        add(1, 1, 1, 1, 0, 4'hF, 9,  2, 0, 0, 0, 0, 16'hFFFF);
        add(1, 1, 1, 1, 0, 4'hF, 1,  3, 0, 0, 0, 0, 16'h0FFF);
        add(1, 1, 1, 1, 0, 4'hF, 3,  3, 0, 0, 0, 0, 16'h0FFF);
        add(1, 1, 1, 0, 0, 4'hF, 2,  3, 0, 0, 0, 0, 16'h0FFF);
        add(1, 1, 1, 0, 0, 4'hF, 1,  4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 1, 4'hF, 19, 4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 0, 4'hF, 21, 4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 0, 4'hF, 1,  5, 0, 0, 1, 1, 16'h0000);
        add(1, 1, 1, 0, 0, 4'hF, 5,  5, 0, 0, 1, 1, 16'h0000);
        add(1, 1, 1, 0, 0, 4'hB, 2,  5, 0, 0, 1, 1, 16'h0000);
        add(1, 1, 1, 0, 0, 4'hB, 1,  4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 0, 4'hB, 2,  4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 0, 4'hF, 21, 4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 0, 4'hF, 1,  5, 0, 0, 1, 1, 16'h0000);
        add(1, 1, 0, 0, 0, 4'hE, 2,  5, 0, 0, 1, 1, 16'h0000);
        add(1, 1, 0, 0, 0, 4'hE, 1,  2, 0, 0, 0, 0, 16'hFFFF);
        add(1, 1, 1, 0, 0, 4'hF, 9,  2, 0, 0, 0, 0, 16'hFFFF);
        add(1, 1, 1, 0, 0, 4'hF, 1,  3, 0, 0, 0, 0, 16'h0FFF);
        add(1, 1, 1, 0, 0, 4'hF, 1,  4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 0, 4'hF, 19, 4, 0, 0, 1, 0, 16'h000F);
        add(1, 1, 1, 0, 0, 4'hF, 1,  5, 0, 0, 1, 1, 16'h0000);

        rst_n = 1'b0;  start = 1'b0;  f2a_init_done = 1'b0;  f2a_tx_pll_locked = 1'b1;
        f2a_tx_cal_busy = 1'b0;  f2a_rx_cal_busy = 1'b0;  f2a_rx_is_lockedtodata = 4'hF;  lpbk_en = 1'b0;
        step(3);
        chk("reset_state", obs(), ex(0, 0, 0, 0, 0, 16'hFFFF));
        chk("reset_lpbk", 23'(a2f_rx_seriallpbken), 23'(0));
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            start                  = tbl[i].start;
            f2a_init_done          = tbl[i].done;
            f2a_tx_pll_locked      = tbl[i].pll;
            f2a_tx_cal_busy        = tbl[i].txcal;
            f2a_rx_cal_busy        = tbl[i].rxcal;
            f2a_rx_is_lockedtodata = tbl[i].ltd;
            step(tbl[i].n);
            chk($sformatf("row%0d", i), obs(),
                ex(tbl[i].st, tbl[i].ist, tbl[i].er, tbl[i].trdy, tbl[i].rrdy, tbl[i].rs));
        end

        // Loopback request while ready
        lpbk_en = 1'b1;
        step(1);
`ifdef HSSI_RST_SEQ_LPBK_EN
        chk("lpbk_relock", obs(), ex(4, 0, 0, 1, 0, 16'h000F));
        chk("lpbk_on", 23'(a2f_rx_seriallpbken), 23'(4'hF));
        wait_state(5, 40, "lpbk_back_rdy");
        chk("lpbk_rdy_val", 23'(a2f_rx_seriallpbken), 23'(4'hF));
`else
        step(4);
        chk("lpbk_ignored", obs(), ex(5, 0, 0, 1, 1, 16'h0000));
        chk("lpbk_tied0", 23'(a2f_rx_seriallpbken), 23'(0));
`endif

        // Abort from RXW by dropping start
        f2a_rx_is_lockedtodata = 4'hB;
        step(3);
        chk("abort_in_rxw", 23'(state_o), 23'(4));
        f2a_rx_is_lockedtodata = 4'hF;
        start = 1'b0;
        step(1);
        chk("abort_idle", obs(), ex(0, 0, 0, 0, 0, 16'hFFFF));

        // Restart, hold in TXW, then async reset mid-cycle
        start = 1'b1;
        f2a_tx_cal_busy = 1'b1;
        wait_state(3, 40, "restart_txw");
        chk("txw_outputs", obs(), ex(3, 0, 0, 0, 0, 16'h0FFF));
`ifdef HSSI_RST_SEQ_LPBK_EN
        lpbk_en = 1'b0;
        step(3);
        chk("lpbk_txw_held", 23'(a2f_rx_seriallpbken), 23'(4'hF));
`endif
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", obs(), ex(0, 0, 0, 0, 0, 16'hFFFF));
        chk("async_rst_lpbk", 23'(a2f_rx_seriallpbken), 23'(0));
        start = 1'b0;
        f2a_init_done = 1'b0;
        f2a_tx_cal_busy = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);

        // Init timeout and ERR exit on start rising edge
        start = 1'b1;
        step(1);
        chk("to_init", obs(), ex(1, 1, 0, 0, 0, 16'hFFFF));
        step(49);
        chk("to_before", obs(), ex(1, 1, 0, 0, 0, 16'hFFFF));
        step(1);
        chk("to_err", obs(), ex(6, 0, 1, 0, 0, 16'hFFFF));
        start = 1'b0;
        step(3);
        chk("err_sticky", obs(), ex(6, 0, 1, 0, 0, 16'hFFFF));
        start = 1'b1;
        step(1);
        chk("err_restart", obs(), ex(1, 1, 0, 0, 0, 16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
